// File: rtl/harvard_avalon_pkg.sv
// Shared state encoding and store-width codes for the Harvard-to-Avalon sequencer.
package harvard_avalon_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        DATA_RD,
        DATA_WR,
        COMMIT,
        HALT
    } seq_state_t;

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;

endpackage

// File: rtl/harvard_avalon_sequencer_byte_lane_gen.sv
// Store lane steering: byte enables and replicated write data for word/half/byte stores.
module byte_lane_gen
    import harvard_avalon_pkg::*;
(
    input  logic [1:0]  i_store_type,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_rt,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_writedata
);

    always_comb begin
        o_byteenable = 4'b1111;
        o_writedata  = i_rt;
        case (i_store_type)
            ST_WORD: ;
            ST_HALF: begin
                o_byteenable = i_addr_lsb[1] ? 4'b1100 : 4'b0011;
                o_writedata  = {2{i_rt[15:0]}};
            end
            ST_BYTE: begin
                o_byteenable = 4'b0001 << i_addr_lsb;
                o_writedata  = {4{i_rt[7:0]}};
            end
            default: ;  // reserved 2'b11 behaves as a word store
        endcase
    end

endmodule

// File: rtl/harvard_avalon_sequencer.sv
// Time-multiplexes instruction fetch and one data access per instruction onto a
// single Avalon-MM master, then strobes the core's clock enable to commit.
//
// state   | meaning
// FETCH   | read instruction at PC (or halt if the core has gone inactive)
// DECODE  | one settle cycle on the latched instruction, sample load/store request
// DATA_RD | bus read at the data address, latch result
// DATA_WR | bus write with lane-steered data
// COMMIT  | one-cycle cpu_clk_enable, then next fetch
// HALT    | parked until reset (program end, timeout or read+write conflict)
module harvard_avalon_sequencer
    import harvard_avalon_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 1023,
    parameter int TIMER_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] cpu_instr_address,
    output logic [31:0] cpu_instr_readdata,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    input  logic [1:0]  cpu_store_type,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        halted,
    output logic        bus_error
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST =
        TIMER_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    seq_state_t         r_state;
    logic [31:0]        r_instr;
    logic [31:0]        r_rdata;
    logic               r_started;
    logic [TIMER_W-1:0] r_timer;
    logic               r_bus_error;

    logic               w_fetch_halt;
    logic               w_timeout;
    logic [3:0]         w_lane_be;
    logic [31:0]        w_lane_wd;
    logic               w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^cpu_instr_address[1:0];
    assign w_fetch_halt     = r_started & ~cpu_active;
    // Fires on the last stall cycle so the request drops on the following cycle.
    assign w_timeout        = (WAIT_TIMEOUT != 0) && (r_timer == TIMEOUT_LAST);

    byte_lane_gen u_lane (
        .i_store_type (cpu_store_type),
        .i_addr_lsb   (cpu_data_address[1:0]),
        .i_rt         (cpu_data_writedata),
        .o_byteenable (w_lane_be),
        .o_writedata  (w_lane_wd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_instr     <= '0;
            r_rdata     <= '0;
            r_started   <= 1'b0;
            r_timer     <= '0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_fetch_halt) begin
                        r_state <= HALT;
                    end else if (!avm_waitrequest) begin
                        r_instr <= avm_readdata;
                        r_timer <= '0;
                        r_state <= DECODE;
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= HALT;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                DECODE: begin
                    if (cpu_data_read && cpu_data_write) begin
                        r_bus_error <= 1'b1;
                        r_state     <= HALT;
                    end else if (cpu_data_write) begin
                        r_state <= DATA_WR;
                    end else if (cpu_data_read) begin
                        r_state <= DATA_RD;
                    end else begin
                        r_state <= COMMIT;
                    end
                end
                DATA_RD, DATA_WR: begin
                    if (!avm_waitrequest) begin
                        if (r_state == DATA_RD) begin
                            r_rdata <= avm_readdata;
                        end
                        r_timer <= '0;
                        r_state <= COMMIT;
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= HALT;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                COMMIT: begin
                    r_started <= 1'b1;
                    r_state   <= FETCH;
                end
                HALT: r_state <= HALT;
                default: r_state <= HALT;
            endcase
        end
    end

    // Outputs are decoded from state; reset forces everything quiet immediately.
    always_comb begin
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_byteenable = '0;
        avm_writedata  = '0;
        cpu_clk_enable = 1'b0;
        halted         = 1'b0;
        if (!reset) begin
            case (r_state)
                FETCH: begin
                    if (!w_fetch_halt) begin
                        avm_read       = 1'b1;
                        avm_address    = {cpu_instr_address[31:2], 2'b00};
                        avm_byteenable = 4'b1111;
                    end
                end
                DATA_RD: begin
                    avm_read       = 1'b1;
                    avm_address    = {cpu_data_address[31:2], 2'b00};
                    avm_byteenable = 4'b1111;
                end
                DATA_WR: begin
                    avm_write      = 1'b1;
                    avm_address    = {cpu_data_address[31:2], 2'b00};
                    avm_byteenable = w_lane_be;
                    avm_writedata  = w_lane_wd;
                end
                COMMIT:  cpu_clk_enable = 1'b1;
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus_error          = r_bus_error & ~reset;
    assign cpu_instr_readdata = reset ? '0 : r_instr;
    assign cpu_data_readdata  = reset ? '0 : r_rdata;

endmodule

// File: tb/tb_harvard_avalon_sequencer.sv
// Randomized bench: a transaction-level model expands each instruction into the
// expected per-cycle bus/strobe picture, and every cycle is compared to the DUT.
module tb_harvard_avalon_sequencer;

    localparam int WT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_active;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [1:0]  cpu_store_type;
    logic [31:0] cpu_data_readdata;
    logic        cpu_clk_enable;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        halted;
    logic        bus_error;

    always #5 clk = ~clk;

    harvard_avalon_sequencer #(.WAIT_TIMEOUT(WT), .TIMER_W(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_active         (cpu_active),
        .cpu_instr_address  (cpu_instr_address),
        .cpu_instr_readdata (cpu_instr_readdata),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_store_type     (cpu_store_type),
        .cpu_data_readdata  (cpu_data_readdata),
        .cpu_clk_enable     (cpu_clk_enable),
        .avm_address        (avm_address),
        .avm_read           (avm_read),
        .avm_write          (avm_write),
        .avm_writedata      (avm_writedata),
        .avm_byteenable     (avm_byteenable),
        .avm_readdata       (avm_readdata),
        .avm_waitrequest    (avm_waitrequest),
        .halted             (halted),
        .bus_error          (bus_error)
    );

    // One expected cycle: slave stimulus plus the outputs the DUT must show.
    typedef struct {
        bit          rd, wr, clken, halt, berr, wait_r;
        logic [31:0] addr, wd, ilatch, dlatch, rdata;
        logic [3:0]  be;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] m_il, m_dl;
    bit          m_berr, m_halt, m_started;
    int          checks   = 0;
    int          failures = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic cyc_t idle_rec();
        cyc_t c;
        c = '{default: '0};
        c.ilatch = m_il;
        c.dlatch = m_dl;
        c.berr   = m_berr;
        c.rdata  = $urandom;
        return c;
    endfunction

    function automatic void push_halt(input int n);
        cyc_t c;
        m_halt = 1'b1;
        for (int i = 0; i < n; i++) begin
            c = idle_rec();
            c.halt = 1'b1;
            q.push_back(c);
        end
    endfunction

    // A transfer is held for `stall` waitrequest cycles; WT stalls in a row abort it.
    function automatic bit push_xfer(input bit rd, input bit wr, input logic [31:0] addr,
                                     input logic [3:0] be, input logic [31:0] wd,
                                     input int stall, input logic [31:0] rdata);
        cyc_t c;
        int   n;
        n = (stall >= WT) ? WT : stall;
        for (int i = 0; i <= n; i++) begin
            if (i == n && stall >= WT) begin
                m_berr = 1'b1;
                push_halt(4);
                return 1'b0;
            end
            c        = idle_rec();
            c.rd     = rd;
            c.wr     = wr;
            c.addr   = addr & 32'hFFFF_FFFC;
            c.be     = be;
            c.wd     = wd;
            c.wait_r = (i < n);
            if (i == n) c.rdata = rdata;
            q.push_back(c);
        end
        return 1'b1;
    endfunction

    // kind: 0 plain, 1 load, 2 store, 3 load+store conflict
    task automatic build_instr(input logic [31:0] pc, input logic [31:0] iword, input int kind,
                               input logic [31:0] daddr, input logic [1:0] st,
                               input logic [31:0] rt, input logic [31:0] ldata,
                               input int s0, input int s1, input bit active);
        cyc_t        c;
        logic [3:0]  be;
        logic [31:0] wd;
        if (m_started && !active) begin
            q.push_back(idle_rec());
            push_halt(4);
            return;
        end
        if (!push_xfer(1'b1, 1'b0, pc, 4'hF, 32'h0, s0, iword)) return;
        m_il = iword;
        q.push_back(idle_rec());
        if (kind == 3) begin
            m_berr = 1'b1;
            push_halt(4);
            return;
        end
        if (kind == 1) begin
            if (!push_xfer(1'b1, 1'b0, daddr, 4'hF, 32'h0, s1, ldata)) return;
            m_dl = ldata;
        end else if (kind == 2) begin
            if (st == 2'b01) begin
                be = (daddr % 4 >= 2) ? 4'hC : 4'h3;
                wd = 32'(rt[15:0]) * 32'h0001_0001;
            end else if (st == 2'b10) begin
                be = 4'(1 << (daddr % 4));
                wd = 32'(rt[7:0]) * 32'h0101_0101;
            end else begin
                be = 4'hF;
                wd = rt;
            end
            if (!push_xfer(1'b0, 1'b1, daddr, be, wd, s1, 32'h0)) return;
        end
        c       = idle_rec();
        c.clken = 1'b1;
        q.push_back(c);
        m_started = 1'b1;
    endtask

    task automatic set_core(input logic [31:0] pc, input bit active, input int kind,
                            input logic [31:0] daddr, input logic [1:0] st, input logic [31:0] rt);
        cpu_instr_address  = pc;
        cpu_active         = active;
        cpu_data_read      = (kind == 1 || kind == 3);
        cpu_data_write     = (kind == 2 || kind == 3);
        cpu_data_address   = daddr;
        cpu_store_type     = st;
        cpu_data_writedata = rt;
    endtask

    // Entered and left at posedge+1: stimulus applied, outputs checked at negedge.
    task automatic play(output int cen_at, output logic [31:0] first_addr,
                        output int rd_cnt, output logic [31:0] dl_at_cen);
        cyc_t e;
        int   idx;
        idx = 0; cen_at = 0; rd_cnt = 0; first_addr = '0; dl_at_cen = '0;
        while (q.size() > 0) begin
            e = q.pop_front();
            idx++;
            avm_waitrequest = e.wait_r;
            avm_readdata    = e.rdata;
            @(negedge clk);
            cmp("ctl{rd,wr,cen,halt,berr}",
                {27'b0, avm_read, avm_write, cpu_clk_enable, halted, bus_error},
                {27'b0, e.rd, e.wr, e.clken, e.halt, e.berr});
            if (e.rd || e.wr) begin
                cmp("avm_address", avm_address, e.addr);
                cmp("avm_byteenable", 32'(avm_byteenable), 32'(e.be));
            end
            if (e.wr) cmp("avm_writedata", avm_writedata, e.wd);
            cmp("cpu_instr_readdata", cpu_instr_readdata, e.ilatch);
            cmp("cpu_data_readdata", cpu_data_readdata, e.dlatch);
            if (idx == 1) first_addr = avm_address;
            if (avm_read) rd_cnt++;
            if (cpu_clk_enable && cen_at == 0) begin
                cen_at    = idx;
                dl_at_cen = cpu_data_readdata;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                cmp("reset_ctl", {27'b0, avm_read, avm_write, cpu_clk_enable, halted, bus_error}, 32'h0);
                cmp("reset_ilatch", cpu_instr_readdata, 32'h0);
                cmp("reset_dlatch", cpu_data_readdata, 32'h0);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        m_il = '0; m_dl = '0; m_berr = 1'b0; m_halt = 1'b0; m_started = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cen, rdc, kind, s0, s1;
        logic [31:0] fa, dl, pc, daddr, rt;
        logic [1:0]  st;
        bit          act;

        reset = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        set_core(32'h0, 1'b1, 0, 32'h0, 2'b00, 32'h0);
        @(posedge clk); #1;
        do_reset(3);

        // First fetch after reset: 3-cycle plain instruction.
        set_core(32'hBFC0_0000, 1'b1, 0, 32'h0, 2'b00, 32'h0);
        build_instr(32'hBFC0_0000, 32'h3C02_0005, 0, 32'h0, 2'b00, 32'h0, 32'h0, 0, 0, 1'b1);
        cmp("model_plain_len", q.size(), 3);
        play(cen, fa, rdc, dl);
        cmp("first_fetch_addr", fa, 32'hBFC0_0000);
        cmp("first_commit_cycle", cen, 3);

        // Byte store at 0x10000003.
        set_core(32'hBFC0_0004, 1'b1, 2, 32'h1000_0003, 2'b10, 32'h0000_00AB);
        build_instr(32'hBFC0_0004, 32'hA043_0003, 2, 32'h1000_0003, 2'b10, 32'h0000_00AB, 32'h0, 0, 0, 1'b1);
        cmp("model_sb_len", q.size(), 4);
        cmp("model_sb_be", 32'(q[2].be), 32'h8);
        cmp("model_sb_wd", q[2].wd, 32'hABAB_ABAB);
        play(cen, fa, rdc, dl);
        cmp("second_fetch_addr", fa, 32'hBFC0_0004);
        cmp("sb_commit_cycle", cen, 4);

        // Word load stalled 3 cycles.
        set_core(32'hBFC0_0008, 1'b1, 1, 32'h1000_0010, 2'b00, 32'h0);
        build_instr(32'hBFC0_0008, 32'h8C44_0010, 1, 32'h1000_0010, 2'b00, 32'h0, 32'hDEAD_BEEF, 0, 3, 1'b1);
        cmp("model_lw_len", q.size(), 7);
        play(cen, fa, rdc, dl);
        cmp("lw_commit_cycle", cen, 7);
        cmp("lw_data_at_commit", dl, 32'hDEAD_BEEF);

        // Core jumps to 0 and goes inactive: no fetch, halt.
        set_core(32'h0, 1'b0, 0, 32'h0, 2'b00, 32'h0);
        build_instr(32'h0, 32'h0, 0, 32'h0, 2'b00, 32'h0, 32'h0, 0, 0, 1'b0);
        play(cen, fa, rdc, dl);
        cmp("inactive_read_count", rdc, 0);
        cmp("inactive_halted", 32'(halted), 32'h1);

        // Fetch stuck in waitrequest: aborted after WT stall cycles.
        do_reset(2);
        set_core(32'h0000_1000, 1'b1, 0, 32'h0, 2'b00, 32'h0);
        build_instr(32'h0000_1000, 32'h0, 0, 32'h0, 2'b00, 32'h0, 32'h0, 9, 0, 1'b1);
        play(cen, fa, rdc, dl);
        cmp("timeout_read_cycles", rdc, WT);
        cmp("timeout_sticky", {30'b0, halted, bus_error}, 32'h3);

        // Reset while a store is stalled.
        do_reset(2);
        set_core(32'h0040_0000, 1'b1, 2, 32'h2000_0006, 2'b01, 32'h1234_ABCD);
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'hA465_0006;
        @(negedge clk);
        cmp("rstw_fetch_read", 32'(avm_read), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        avm_waitrequest = 1'b1;
        @(negedge clk);
        cmp("rstw_write_on", 32'(avm_write), 32'h1);
        cmp("rstw_half_be", 32'(avm_byteenable), 32'hC);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        cmp("rstw_write_dropped", 32'(avm_write), 32'h0);
        cmp("rstw_bus_error", 32'(bus_error), 32'h0);
        @(posedge clk); #1;
        do_reset(1);
        set_core(32'h0040_0000, 1'b1, 0, 32'h0, 2'b00, 32'h0);
        build_instr(32'h0040_0000, 32'h0000_0000, 0, 32'h0, 2'b00, 32'h0, 32'h0, 1, 0, 1'b1);
        play(cen, fa, rdc, dl);
        cmp("rstw_refetch_addr", fa, 32'h0040_0000);

        // Randomized programs.
        for (int run = 0; run < 12; run++) begin
            do_reset(2);
            pc = $urandom;
            for (int n = 0; n < 30 && !m_halt; n++) begin
                kind  = $urandom_range(0, 99);
                kind  = (kind < 40) ? 0 : (kind < 70) ? 1 : (kind < 97) ? 2 : 3;
                daddr = $urandom;
                rt    = $urandom;
                st    = 2'($urandom_range(0, 3));
                s0    = ($urandom_range(0, 39) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
                s1    = ($urandom_range(0, 39) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
                act   = (n == 0) || ($urandom_range(0, 24) != 0);
                set_core(pc, act, act ? kind : 0, daddr, st, rt);
                build_instr(pc, $urandom, act ? kind : 0, daddr, st, rt, $urandom, s0, s1, act);
                play(cen, fa, rdc, dl);
                pc = ($urandom_range(0, 9) == 0) ? $urandom : pc + 32'd4;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/harvard_avalon_sequencer.md
Name: harvard_avalon_sequencer

Overview:
Sequences the single-cycle Harvard MIPS core onto one shared Avalon-MM master port.
- Fetches each instruction over the bus and latches it.
- Performs at most one data read or write per instruction.
- Pulses the core's clk_enable for exactly one cycle to commit the instruction.
- Sits between the core and the Avalon interconnect; time-multiplexes instruction and data traffic on one port.

Parameters:
WAIT_TIMEOUT, 1023, max cycles a single transfer may be held by waitrequest before abort; 0 disables timeout
TIMER_W, 10, width of the waitrequest counter; must satisfy 2**TIMER_W > WAIT_TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_active  in  1  core active flag
cpu_instr_address  in  32  core PC
cpu_instr_readdata  out  32  latched instruction presented to core
cpu_data_address  in  32  core data address (ALU result)
cpu_data_read  in  1  core load request
cpu_data_write  in  1  core store request
cpu_data_writedata  in  32  core store data (unshifted rt)
cpu_store_type  in  2  00 word, 01 half, 10 byte, 11 treated as word
cpu_data_readdata  out  32  latched load data presented to core
cpu_clk_enable  out  1  one-cycle commit strobe to core
avm_address  out  32  word-aligned bus address
avm_read  out  1  bus read
avm_write  out  1  bus write
avm_writedata  out  32  lane-replicated store data
avm_byteenable  out  4  byte lanes
avm_readdata  in  32  bus read data, valid in the cycle waitrequest is low
avm_waitrequest  in  1  slave stall
halted  out  1  sequencer stopped (program end or error)
bus_error  out  1  sticky: timeout or read+write conflict

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- While reset is high, all outputs are 0 and internal state is cleared: state=FETCH, instr latch=0, data latch=0, started=0, timer=0.
- Reset asserted mid-transfer drops avm_read/avm_write the next cycle. No completion is awaited.
- Avalon rules: read/write, address, writedata and byteenable are held stable until a cycle with waitrequest=0. That cycle completes the transfer. Fixed latency 0; no readdatavalid.
- States and outputs are Moore, decoded from state:
  - FETCH:
    - If started=1 and cpu_active=0 -> HALT; no bus read is issued.
    - Otherwise avm_read=1 with avm_address={cpu_instr_address[31:2],2'b00} and byteenable=1111.
    - On waitrequest=0: latch avm_readdata into the instr latch -> DECODE.
  - DECODE: one cycle so core combinational logic settles on the latched instruction; cpu_clk_enable=0. Sample the core's requests:
    - read and write both set -> set bus_error -> HALT.
    - write -> DATA_WR.
    - read -> DATA_RD.
    - neither -> COMMIT.
  - DATA_RD:
    - avm_read=1, aligned data address, byteenable=1111.
    - On waitrequest=0: latch avm_readdata -> COMMIT.
  - DATA_WR:
    - avm_write=1, aligned data address.
    - word (00 or 11): byteenable=1111, writedata=rt.
    - half (01): byteenable = addr[1] ? 1100 : 0011, writedata={2{rt[15:0]}}.
    - byte (10): byteenable = 0001<<addr[1:0], writedata={4{rt[7:0]}}.
    - Word accesses with addr[1:0]!=0 are not flagged.
    - On waitrequest=0 -> COMMIT.
  - COMMIT: cpu_clk_enable=1 for exactly one cycle; set started=1 -> FETCH.
  - HALT: halted=1; no bus activity; exits only via reset.
- cpu_instr_readdata and cpu_data_readdata are always the latched values. The data latch holds its value until the next DATA_RD completion.
- Timeout (FETCH/DATA_RD/DATA_WR):
  - timer clears on entry and increments each cycle waitrequest=1.
  - If timer reaches WAIT_TIMEOUT (nonzero) while waitrequest=1: drop request next cycle, set bus_error, -> HALT.
- Latency with waitrequest always low:
  - no data access: 3 cycles per instruction;
  - load or store: 4 cycles;
  - each waitrequest cycle adds 1.

Decomposition:
- Package harvard_avalon_pkg holds:
  - state enum {FETCH, DECODE, DATA_RD, DATA_WR, COMMIT, HALT};
  - store_type localparams ST_WORD=2'b00, ST_HALF=2'b01, ST_BYTE=2'b10.
- Sub-module byte_lane_gen: combinational; inputs store_type, addr[1:0], rt; outputs byteenable, writedata.

Test Plan:
- Reset, slave with no waitrequest; fetch of 0x3C020005 at PC 0xBFC00000 -> avm_read at 0xBFC00000 in cycle 1; cpu_clk_enable pulses in cycle 3; next read at 0xBFC00004.
- Store byte, addr 0x10000003, rt=0x000000AB -> avm_write with byteenable=1000, writedata=0xABABABAB, avm_address=0x10000000, 4-cycle instruction.
- Load word with waitrequest held 3 cycles, readdata 0xDEADBEEF -> address/read stable all 4 cycles; cpu_data_readdata=0xDEADBEEF from COMMIT onward; instruction takes 7 cycles.
- WAIT_TIMEOUT=4, waitrequest stuck high on fetch -> read dropped after 4 stall cycles; bus_error=1 and halted=1 persist until reset.
- After ≥1 commit, core drops cpu_active (jump to 0) -> no further avm_read; halted=1.
- Reset asserted during DATA_WR with waitrequest high -> next cycle avm_write=0 and state FETCH; bus_error=0.
